// File: rtl/ssd_bcd_chain.sv
// ssd_bcd_chain: cascadable up/down BCD counter with preset and seven-segment outputs.
// Define SSD_BLINK_EN to add per-digit blinking driven by a BLINK_DIV-cycle half-period.
`ifndef ZERO
`define ZERO  7'h3F
`define ONE   7'h06
`define TWO   7'h5B
`define THREE 7'h4F
`define FOUR  7'h66
`define FIVE  7'h6D
`define SIX   7'h7D
`define SEVEN 7'h07
`define EIGHT 7'h7F
`define NINE  7'h6F
`endif

module ssd_bcd_chain #(
  parameter int          NUM_DIG   = 2,
  parameter logic [15:0] WRAP_BCD  = 16'h0059,
  parameter int          BLINK_DIV = 25000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dsyn_rst_n,
  input  logic                 tick,
  input  logic                 up_dn,
  input  logic                 load,
  input  logic [4*NUM_DIG-1:0] load_val,
  input  logic [NUM_DIG-1:0]   blink_mask,
  output logic [4*NUM_DIG-1:0] bcd_out,
  output logic [7*NUM_DIG-1:0] ssd_out,
  output logic                 carry_out,
  output logic                 load_err
);
  localparam int W = 4*NUM_DIG;
  localparam logic [W-1:0] WRAP = WRAP_BCD[W-1:0];

  logic [W-1:0] inc_v, dec_v;
  logic [NUM_DIG-1:0] blank;
  logic c, b, load_ok, at_wrap, at_zero;

  // Ripple the digit carry/borrow; packed BCD compares numerically once nibbles are valid.
  always_comb begin
    inc_v = bcd_out;
    dec_v = bcd_out;
    c = 1'b1;
    b = 1'b1;
    load_ok = load_val <= WRAP;
    for (int i = 0; i < NUM_DIG; i++) begin
      inc_v[4*i+:4] = c ? (bcd_out[4*i+:4] == 4'd9 ? 4'd0 : bcd_out[4*i+:4] + 4'd1) : bcd_out[4*i+:4];
      dec_v[4*i+:4] = b ? (bcd_out[4*i+:4] == 4'd0 ? 4'd9 : bcd_out[4*i+:4] - 4'd1) : bcd_out[4*i+:4];
      c = c && bcd_out[4*i+:4] == 4'd9;
      b = b && bcd_out[4*i+:4] == 4'd0;
      load_ok = load_ok && load_val[4*i+:4] <= 4'd9;
    end
  end

  assign at_wrap = bcd_out == WRAP;
  assign at_zero = bcd_out == '0;
  assign carry_out = rst_n && tick && !load && (up_dn ? at_wrap : at_zero);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out  <= '0;
      load_err <= 1'b0;
    end else begin
      load_err <= load && !load_ok;
      if (load) begin
        if (load_ok) bcd_out <= load_val;
      end else if (tick) begin
        bcd_out <= up_dn ? (at_wrap ? '0 : inc_v) : (at_zero ? WRAP : dec_v);
      end
    end
  end

`ifdef SSD_BLINK_EN
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] bcnt;
  logic blink_phase;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcnt        <= '0;
      blink_phase <= 1'b1;
    end else if (bcnt == BW'(BLINK_DIV - 1)) begin
      bcnt        <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      bcnt <= bcnt + 1'b1;
    end
  end
  assign blank = blink_phase ? '0 : blink_mask;
`else
  logic unused_blink;
  assign unused_blink = ^blink_mask;
  assign blank = '0;
`endif

  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'd0: seg = `ZERO;
      4'd1: seg = `ONE;
      4'd2: seg = `TWO;
      4'd3: seg = `THREE;
      4'd4: seg = `FOUR;
      4'd5: seg = `FIVE;
      4'd6: seg = `SIX;
      4'd7: seg = `SEVEN;
      4'd8: seg = `EIGHT;
      4'd9: seg = `NINE;
      default: seg = 7'd0;
    endcase
  endfunction

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_seg
    assign ssd_out[7*g+:7] = (!dsyn_rst_n || blank[g]) ? 7'd0 : seg(bcd_out[4*g+:4]);
  end
endmodule
